// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage of the RISC datapath.
//
// Holds the NREG x DW general register file. A request in IDLE latches the
// two source indices and the shift code, then the single read port fetches
// A (READ_A) and B (READ_B) into the operand latches. HOLD presents them
// with valid=1 until ack. The writeback port writes in any state, and a
// write that hits the register being read in the same cycle is forwarded.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   start, rn, rm       fetch request and source indices (A, B)
//   shift_in            shift code travelling with B
//   ack                 downstream consumed the operand pair
//   w_en, w_num, w_data register-file write port
//   busy, valid         status: not IDLE / operand pair available
//   ain, bin, shift     operand latches and latched shift code
module operand_fetch #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    rn,
  input  logic [2:0]    rm,
  input  logic [1:0]    shift_in,
  input  logic          ack,
  input  logic          w_en,
  input  logic [2:0]    w_num,
  input  logic [DW-1:0] w_data,
  output logic          busy,
  output logic          valid,
  output logic [DW-1:0] ain,
  output logic [DW-1:0] bin,
  output logic [1:0]    shift
);

  typedef enum logic [1:0] {S_IDLE, S_READ_A, S_READ_B, S_HOLD} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               rn_q, rn_d;
  logic [2:0]               rm_q, rm_d;
  logic [1:0]               sh_q, sh_d;
  logic [DW-1:0]            ain_q, ain_d;
  logic [DW-1:0]            bin_q, bin_d;
  logic [NREG-1:0][DW-1:0]  rf_q, rf_d;

  logic [2:0]    rd_num;
  logic [DW-1:0] rd_data;

  // Single read port: index chosen by the read phase. A same-cycle write to
  // that register wins over the stale array contents.
  always_comb begin
    rd_num  = (state_q == S_READ_A) ? rn_q : rm_q;
    rd_data = (w_en && (w_num == rd_num)) ? w_data : rf_q[rd_num];
  end

  always_comb begin
    rf_d = rf_q;
    if (w_en) rf_d[w_num] = w_data;
  end

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    sh_d    = sh_q;
    ain_d   = ain_q;
    bin_d   = bin_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rn_d    = rn;
          rm_d    = rm;
          sh_d    = shift_in;
          state_d = S_READ_A;
        end
      end
      S_READ_A: begin
        ain_d   = rd_data;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        bin_d   = rd_data;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Latches are frozen here, so later writes to rn/rm do not leak in.
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      sh_q    <= '0;
      ain_q   <= '0;
      bin_q   <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      sh_q    <= sh_d;
      ain_q   <= ain_d;
      bin_q   <= bin_d;
      rf_q    <= rf_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = (state_q == S_HOLD);
  assign ain   = ain_q;
  assign bin   = bin_q;
  assign shift = sh_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_operand_fetch;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    rn = '0, rm = '0, w_num = '0;
  logic [1:0]    shift_in = '0;
  logic          ack = 1'b0, w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          busy, valid;
  logic [DW-1:0] ain, bin;
  logic [1:0]    shift;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.DW(DW), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rn(rn), .rm(rm),
    .shift_in(shift_in), .ack(ack), .w_en(w_en), .w_num(w_num),
    .w_data(w_data), .busy(busy), .valid(valid), .ain(ain), .bin(bin),
    .shift(shift)
  );

  always #5 clk = ~clk;

  // Behavioural model: register array plus "edges since the request was
  // accepted" (0 = no fetch in progress, 3 = operands presented).
  logic [DW-1:0] m_rf [8];
  int            m_age = 0;
  logic [2:0]    m_rn = '0, m_rm = '0;
  logic [1:0]    m_sh = '0;
  logic [DW-1:0] m_ain = '0, m_bin = '0;

  initial for (int i = 0; i < 8; i++) m_rf[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_age = 0; m_rn = '0; m_rm = '0; m_sh = '0; m_ain = '0; m_bin = '0;
    end else begin
      // The write commits at this edge; a read at the same edge sees the
      // post-write array, which is exactly the forwarding rule.
      if (w_en) m_rf[w_num] = w_data;
      if (m_age == 0) begin
        if (start) begin
          m_rn = rn; m_rm = rm; m_sh = shift_in; m_age = 1;
        end
      end else if (m_age == 1) begin
        m_ain = m_rf[m_rn]; m_age = 2;
      end else if (m_age == 2) begin
        m_bin = m_rf[m_rm]; m_age = 3;
      end else if (ack) begin
        m_age = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, away from the active edge.
  always @(negedge clk) begin
    chk("busy",  {31'd0, busy},  {31'd0, m_age != 0});
    chk("valid", {31'd0, valid}, {31'd0, m_age == 3});
    chk("shift", {30'd0, shift}, {30'd0, m_sh});
    chk("ain",   {16'd0, ain},   {16'd0, m_ain});
    chk("bin",   {16'd0, bin},   {16'd0, m_bin});
  end

  // Inputs change 2 time units after the negedge, clear of both edges.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic idle_in();
    start = 0; ack = 0; w_en = 0;
  endtask

  task automatic wr(input logic [2:0] num, input logic [DW-1:0] d);
    w_en = 1; w_num = num; w_data = d;
    tick();
    w_en = 0;
  endtask

  // Request, then wait until the pair is presented (3 edges from the start edge).
  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    start = 1; rn = a; rm = b; shift_in = s;
    tick();
    start = 0;
    tick(2);
  endtask

  task automatic do_ack();
    ack = 1;
    tick();
    ack = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    tick(2);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ain",   {16'd0, ain},   32'd0);
    rst_n = 1;
    tick();

    // Reset contents
    fetch(3, 5, 2'b01);
    chk("rc_valid", {31'd0, valid}, 32'd1);
    chk("rc_ain",   {16'd0, ain},   32'h0000);
    chk("rc_bin",   {16'd0, bin},   32'h0000);
    chk("rc_shift", {30'd0, shift}, 32'd1);
    do_ack();

    // Basic fetch with hold
    wr(1, 16'h1234);
    wr(2, 16'hF00F);
    fetch(1, 2, 2'b11);
    chk("bf_ain",   {16'd0, ain},   32'h1234);
    chk("bf_bin",   {16'd0, bin},   32'hF00F);
    chk("bf_shift", {30'd0, shift}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bf_hold_valid", {31'd0, valid}, 32'd1);
    end
    // Snapshot: write reg1 while holding
    wr(1, 16'hBEEF);
    chk("snap_ain", {16'd0, ain}, 32'h1234);
    do_ack();
    chk("bf_ack_valid", {31'd0, valid}, 32'd0);
    chk("bf_ack_busy",  {31'd0, busy},  32'd0);
    fetch(1, 1, 2'b00);
    chk("snap_refetch", {16'd0, ain}, 32'hBEEF);
    do_ack();

    // Forwarding on both read phases
    wr(4, 16'h0001);
    start = 1; rn = 4; rm = 4; shift_in = 2'b10;
    tick();
    start = 0;
    wr(4, 16'hAAAA);
    wr(4, 16'h5555);
    chk("fw_valid", {31'd0, valid}, 32'd1);
    chk("fw_ain",   {16'd0, ain},   32'hAAAA);
    chk("fw_bin",   {16'd0, bin},   32'h5555);
    do_ack();
    fetch(4, 4, 2'b00);
    chk("fw_commit", {16'd0, bin}, 32'h5555);
    do_ack();

    // Ignored start during READ_B, ignored ack in IDLE
    start = 1; rn = 1; rm = 2; shift_in = 2'b01;
    tick();
    start = 0;
    tick();
    start = 1; rn = 7; rm = 7; shift_in = 2'b10;
    tick();
    start = 0;
    chk("ign_ain",   {16'd0, ain},   32'hBEEF);
    chk("ign_bin",   {16'd0, bin},   32'hF00F);
    chk("ign_shift", {30'd0, shift}, 32'd1);
    do_ack();
    ack = 1;
    tick();
    ack = 0;
    chk("ign_ack_busy", {31'd0, busy}, 32'd0);

    // Reset during READ_B
    start = 1; rn = 1; rm = 2;
    tick();
    start = 0;
    tick();
    rst_n = 0;
    #1;
    chk("mr_valid", {31'd0, valid}, 32'd0);
    chk("mr_busy",  {31'd0, busy},  32'd0);
    chk("mr_ain",   {16'd0, ain},   32'd0);
    chk("mr_bin",   {16'd0, bin},   32'd0);
    tick();
    rst_n = 1;
    tick();
    fetch(1, 2, 2'b11);
    chk("mr_rf_a", {16'd0, ain}, 32'd0);
    chk("mr_rf_b", {16'd0, bin}, 32'd0);
    do_ack();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 2) == 0);
      ack      = ($urandom_range(0, 2) == 0);
      w_en     = ($urandom_range(0, 1) == 0);
      w_num    = 3'($urandom_range(0, 7));
      w_data   = 16'($urandom);
      rn       = 3'($urandom_range(0, 7));
      rm       = 3'($urandom_range(0, 7));
      shift_in = 2'($urandom_range(0, 3));
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
      rst_n = 1;
    end
    idle_in();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
